// File: rtl/hazard_ctrl_md.sv
// Hazard unit for the 5-stage MIPS pipeline: Tuse/Tnew stalls, D/E/M forwarding
// selects, mult/div busy tracking and a saturating stall-cycle counter.
module hazard_ctrl_md #(
    parameter int TW          = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_rs_d,
    input  logic [4:0]       i_rt_d,
    input  logic [4:0]       i_rs_e,
    input  logic [4:0]       i_rt_e,
    input  logic [4:0]       i_rt_m,
    input  logic [4:0]       i_wa_e,
    input  logic [4:0]       i_wa_m,
    input  logic [4:0]       i_wa_w,
    input  logic             i_we_e,
    input  logic             i_we_m,
    input  logic             i_we_w,
    input  logic [TW-1:0]    i_tnew_e,
    input  logic [TW-1:0]    i_tnew_m,
    input  logic [TW-1:0]    i_rs_tuse,
    input  logic [TW-1:0]    i_rt_tuse,
    input  logic             i_md_use_d,
    input  logic             i_md_start_e,
    input  logic             i_md_is_div_e,
    output logic             o_stall,
    output logic             o_flush_e,
    output logic             o_md_busy,
    output logic [1:0]       o_fwd_rs_d,
    output logic [1:0]       o_fwd_rt_d,
    output logic [1:0]       o_fwd_rs_e,
    output logic [1:0]       o_fwd_rt_e,
    output logic             o_fwd_rt_m,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int MAX_C = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int BW    = $clog2(MAX_C + 1);

    logic [BW-1:0]    r_md_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_e_rs_d, w_e_rt_d, w_m_rs_d, w_m_rt_d, w_w_rs_d, w_w_rt_d;
    logic w_m_rs_e, w_m_rt_e, w_w_rs_e, w_w_rt_e, w_w_rt_m;
    logic w_e_ready, w_data_stall, w_md_stall, w_stall;

    // $0 is hardwired to zero, so a write to it never produces a match.
    function automatic logic f_match(input logic we, input logic [4:0] wa, input logic [4:0] r);
        return we && (wa != 5'd0) && (wa == r);
    endfunction

    assign w_e_rs_d = f_match(i_we_e, i_wa_e, i_rs_d);
    assign w_e_rt_d = f_match(i_we_e, i_wa_e, i_rt_d);
    assign w_m_rs_d = f_match(i_we_m, i_wa_m, i_rs_d);
    assign w_m_rt_d = f_match(i_we_m, i_wa_m, i_rt_d);
    assign w_w_rs_d = f_match(i_we_w, i_wa_w, i_rs_d);
    assign w_w_rt_d = f_match(i_we_w, i_wa_w, i_rt_d);
    assign w_m_rs_e = f_match(i_we_m, i_wa_m, i_rs_e);
    assign w_m_rt_e = f_match(i_we_m, i_wa_m, i_rt_e);
    assign w_w_rs_e = f_match(i_we_w, i_wa_w, i_rs_e);
    assign w_w_rt_e = f_match(i_we_w, i_wa_w, i_rt_e);
    assign w_w_rt_m = f_match(i_we_w, i_wa_w, i_rt_m);

    assign w_e_ready = (i_tnew_e == '0);

    assign w_data_stall = (w_e_rs_d && (i_rs_tuse < i_tnew_e)) ||
                          (w_e_rt_d && (i_rt_tuse < i_tnew_e)) ||
                          (w_m_rs_d && (i_rs_tuse < i_tnew_m)) ||
                          (w_m_rt_d && (i_rt_tuse < i_tnew_m));
    assign w_md_stall   = i_md_use_d && (i_md_start_e || o_md_busy);
    assign w_stall      = w_data_stall || w_md_stall;

    assign o_stall     = w_stall;
    assign o_flush_e   = w_stall;
    assign o_md_busy   = (r_md_cnt != '0);
    assign o_fwd_rt_m  = w_w_rt_m;
    assign o_stall_cnt = r_stall_cnt;

    // Nearest producer wins; E only forwards once its result exists.
    always_comb begin
        o_fwd_rs_d = 2'd0;
        o_fwd_rt_d = 2'd0;
        o_fwd_rs_e = 2'd0;
        o_fwd_rt_e = 2'd0;
        if (w_e_rs_d && w_e_ready) o_fwd_rs_d = 2'd3;
        else if (w_m_rs_d)         o_fwd_rs_d = 2'd2;
        else if (w_w_rs_d)         o_fwd_rs_d = 2'd1;
        if (w_e_rt_d && w_e_ready) o_fwd_rt_d = 2'd3;
        else if (w_m_rt_d)         o_fwd_rt_d = 2'd2;
        else if (w_w_rt_d)         o_fwd_rt_d = 2'd1;
        if (w_m_rs_e)              o_fwd_rs_e = 2'd2;
        else if (w_w_rs_e)         o_fwd_rs_e = 2'd1;
        if (w_m_rt_e)              o_fwd_rt_e = 2'd2;
        else if (w_w_rt_e)         o_fwd_rt_e = 2'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_md_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (i_md_start_e)
                r_md_cnt <= i_md_is_div_e ? BW'(DIV_CYCLES) : BW'(MULT_CYCLES);
            else if (r_md_cnt != '0)
                r_md_cnt <= r_md_cnt - BW'(1);
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_ctrl_md.md
Name: hazard_ctrl_md

Overview:
- Next-generation hazard unit for the 5-stage MIPS pipeline (stages F, D, E, M, W).
- Decides Tuse/Tnew-based stalls and generates forwarding selects for the D, E and M consumers.
- New over the previous generation: forwarding from E when its result is ready (Tnew_e==0), and a multi-cycle mult/div busy tracker that stalls HI/LO consumers.
- Also new: a saturating stall-cycle performance counter and a parametrised Tuse/Tnew width.

Parameters:
- TW, 2, width of every Tuse/Tnew field.
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 32, width of stall_cnt.

Ports:
- clk  in  1  system clock. One clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rs_d, rt_d  in  5  D-stage source registers.
- rs_e, rt_e  in  5  E-stage source registers.
- rt_m  in  5  M-stage store-data register.
- wa_e, wa_m, wa_w  in  5  destination register per stage.
- we_e, we_m, we_w  in  1  register-write enable per stage.
- tnew_e, tnew_m  in  TW  cycles until the result is available.
- rs_tuse, rt_tuse  in  TW  D-stage use distance.
- md_use_d  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- md_start_e  in  1  E instruction starts mult/div this cycle.
- md_is_div_e  in  1  qualifies md_start_e: 1=div, 0=mult.
- stall  out  1  freeze PC and F/D; insert bubble into D/E.
- flush_e  out  1  equal to stall.
- md_busy  out  1  mult/div unit is busy.
- fwd_rs_d, fwd_rt_d  out  2  select for D operands: 3=E, 2=M, 1=W, 0=regfile.
- fwd_rs_e, fwd_rt_e  out  2  select for E operands: 2=M, 1=W, 0=regfile.
- fwd_rt_m  out  1  M store data taken from W.
- stall_cnt  out  CNT_W  stall cycles counted since reset.

Behaviour:
- Match condition (stage X, register r): wa_X != 0 && wa_X == r && we_X. Register $0 never matches.
- Data stall (combinational):
  - any E match on rs_d with rs_tuse < tnew_e;
  - same for rt_d with rt_tuse;
  - same for the M stage using tnew_m.
- MD stall (combinational): md_use_d && (md_start_e || md_busy).
- stall = data stall || MD stall.
- Forward priority is nearest stage first:
  - D selects: E (only if tnew_e==0), else M, else W, else 0.
  - E selects: M, else W, else 0.
  - fwd_rt_m is the W match on rt_m.
- Busy counter cnt is a register wide enough to hold max(MULT_CYCLES, DIV_CYCLES).
  - On a clock edge with md_start_e=1: cnt <= DIV_CYCLES if md_is_div_e, else MULT_CYCLES. A start while busy reloads the counter.
  - Otherwise, if cnt != 0: cnt <= cnt-1.
  - md_busy = (cnt != 0), a registered-state output. It is high for exactly LAT cycles, starting the cycle after the start cycle.
- stall_cnt increments by 1 on each edge where stall=1. It saturates at all-ones with no wrap.
- Reset (synchronous, takes priority over all updates):
  - cnt=0, md_busy=0, stall_cnt=0 at the next edge.
  - A reset asserted mid-operation abandons the busy period.
  - Combinational outputs follow their inputs during reset. With all we_*=0 and md_*=0 they are all 0.
- Simultaneous events:
  - md_start_e together with md_use_d stalls in that cycle and still loads the counter.
  - A data stall and an MD stall in the same cycle count as one stall cycle.
- Outputs must have no latches, and there is no combinational path from stall back into the counter other than through the stall_cnt increment.

Test Plan:
- lw $8 in E (tnew_e=2), D add using rs=$8 with rs_tuse=1 -> stall=1, flush_e=1, stall_cnt 0→1. The next cycle, with lw in M and tnew_m=1, gives stall=0 and fwd_rs_d=2.
- E addu writes $9 with tnew_e=0, D beq with rs=$9 and rs_tuse=0 -> stall=0, fwd_rs_d=3. Repeat with wa_e=0 -> fwd_rs_d=0.
- md_start_e=1 with md_is_div_e=0, followed by D mflo (md_use_d=1) held -> stall high in the start cycle plus 5 busy cycles (6 total), then drops. md_busy falls exactly 5 cycles after rising, and stall_cnt reaches 6.
- Div start (md_is_div_e=1), then reset asserted on busy cycle 3 -> md_busy=0 and stall_cnt=0 after that edge, and stall drops the same edge.
- Same register in both M and W (wa_m=wa_w=$4, both we=1), rs_e=$4 -> fwd_rs_e=2. Then set we_m=0 -> fwd_rs_e=1.
- Force stall for 2^CNT_W+3 cycles with CNT_W overridden to 4 -> stall_cnt holds 15 with no wrap.
